// File: rtl/pic_io_port.sv
// PIC-style bidirectional I/O port.
// Holds the output latch and TRIS register, synchronises the pin levels, and
// raises two sticky flags: intf for a selected edge on bit 0, and rbif for
// interrupt-on-change on the masked input bits.
module pic_io_port #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   IOC_MASK    = 8'hF0,
  parameter int                 SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             intedg,
  input  logic [1:0]       flag_clr,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic [WIDTH-1:0] tris_val,
  output logic [WIDTH-1:0] port_rd,
  output logic             intf,
  output logic             rbif
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_pin_out;
  logic [WIDTH-1:0] r_tris;
  logic [WIDTH-1:0] r_ref;
  logic             r_b0_dly;
  logic             r_intf;
  logic             r_rbif;

  logic [WIDTH-1:0] w_port_rd;
  logic [WIDTH-1:0] w_chg_src;
  logic             w_chg_any;
  logic             w_b0_edge;

  assign w_port_rd = r_sync[SYNC_STAGES-1];

  // A change source is an input-configured, IOC-eligible bit whose level
  // differs from the reference captured at the last PORT read.
  assign w_chg_src = IOC_MASK & r_tris & (w_port_rd ^ r_ref);
  assign w_chg_any = |w_chg_src;

  // Bit-0 edge against its one-cycle-delayed copy; intedg only selects which
  // transition counts, so toggling intedg alone never produces an edge.
  assign w_b0_edge = intedg ? (w_port_rd[0] & ~r_b0_dly)
                            : (~w_port_rd[0] & r_b0_dly);

  // Pin synchroniser chain; the last stage is the visible port_rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Output latch and TRIS writes, independent of each other and of reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pin_out <= '0;
      r_tris    <= '1;
    end else if (wr_en) begin
      if (wr_sel) r_tris    <= wr_data;
      else        r_pin_out <= wr_data;
    end
  end

  // Change reference and bit-0 delay; mismatch is judged on the old reference.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref    <= '0;
      r_b0_dly <= 1'b0;
    end else begin
      if (rd_en) r_ref <= w_port_rd;
      r_b0_dly <= w_port_rd[0];
    end
  end

  // Sticky flags: a set condition beats a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_intf <= 1'b0;
      r_rbif <= 1'b0;
    end else begin
      if (w_b0_edge)        r_intf <= 1'b1;
      else if (flag_clr[0]) r_intf <= 1'b0;
      if (w_chg_any)        r_rbif <= 1'b1;
      else if (flag_clr[1]) r_rbif <= 1'b0;
    end
  end

  assign pin_out  = r_pin_out;
  assign tris_val = r_tris;
  assign pin_oe   = ~r_tris;
  assign port_rd  = w_port_rd;
  assign intf     = r_intf;
  assign rbif     = r_rbif;

endmodule

// File: tb/tb_pic_io_port.sv
// Bench for pic_io_port: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a history-based model.
module tb_pic_io_port;

  localparam int          W    = 8;
  localparam logic [7:0]  IOC  = 8'hF0;
  localparam int          SYNC = 2;

  logic       clk = 1'b0;
  logic       rst, wr_en, wr_sel, rd_en, intedg;
  logic [7:0] wr_data, pin_in;
  logic [1:0] flag_clr;
  logic [7:0] pin_out, pin_oe, tris_val, port_rd;
  logic       intf, rbif;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  pic_io_port #(.WIDTH(W), .IOC_MASK(IOC), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_en(rd_en), .intedg(intedg), .flag_clr(flag_clr), .pin_in(pin_in),
    .pin_out(pin_out), .pin_oe(pin_oe), .tris_val(tris_val), .port_rd(port_rd),
    .intf(intf), .rbif(rbif)
  );

  always #5 clk = ~clk;

  // Model state: m_hist[k] is the pin sample taken k+1 edges ago, so the
  // visible port level is m_hist[SYNC-1] and its previous value m_hist[SYNC].
  logic [7:0] m_hist [0:SYNC];
  logic [7:0] m_tris, m_out, m_ref;
  logic       m_intf, m_rbif;

  always @(posedge clk) begin : model
    logic [7:0] prd;
    logic       prev0, chg, e_hit;
    if (rst) begin
      for (int i = 0; i <= SYNC; i++) m_hist[i] = 8'h00;
      m_tris = 8'hFF; m_out = 8'h00; m_ref = 8'h00;
      m_intf = 1'b0;  m_rbif = 1'b0;
    end else begin
      prd   = m_hist[SYNC-1];
      prev0 = m_hist[SYNC][0];
      chg   = ((IOC & m_tris & (prd ^ m_ref)) != 8'h00);
      e_hit = intedg ? (prd[0] && !prev0) : (!prd[0] && prev0);
      m_rbif = chg   || (m_rbif && !flag_clr[1]);
      m_intf = e_hit || (m_intf && !flag_clr[0]);
      if (rd_en) m_ref = prd;
      if (wr_en) begin
        if (wr_sel) m_tris = wr_data;
        else        m_out  = wr_data;
      end
      for (int i = SYNC; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pin_in;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pin_out",  pin_out,        m_out);
      chk("m_tris_val", tris_val,       m_tris);
      chk("m_pin_oe",   pin_oe,         ~m_tris);
      chk("m_port_rd",  port_rd,        m_hist[SYNC-1]);
      chk("m_intf",     {7'd0, intf},   {7'd0, m_intf});
      chk("m_rbif",     {7'd0, rbif},   {7'd0, m_rbif});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
    intedg = 1'b0; flag_clr = 2'b00; pin_in = 8'h00;
    step(2);
    chk_en = 1'b1;
    rst = 1'b0;
    step(1);
    chk("rst_tris",    tris_val, 8'hFF);
    chk("rst_pin_out", pin_out,  8'h00);
    chk("rst_pin_oe",  pin_oe,   8'h00);
    chk("rst_flags",   {6'd0, intf, rbif}, 8'h00);

    // TRIS and PORT writes
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = 8'h0F; step(1); wr_en = 1'b0;
    chk("wr_tris_oe", pin_oe, 8'hF0);
    wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'hA5; step(1); wr_en = 1'b0;
    chk("wr_port", pin_out, 8'hA5);

    // Change on bit 4 with all inputs: rbif exactly three cycles later
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = 8'hFF; step(1); wr_en = 1'b0;
    pin_in = 8'h10; step(2);
    chk("ioc_early", {7'd0, rbif}, 8'h00);
    step(1);
    chk("ioc_set", {7'd0, rbif}, 8'h01);

    // Clear without read: mismatch persists, rbif stays/reasserts
    flag_clr = 2'b10; step(1); flag_clr = 2'b00;
    chk("clr_no_rd", {7'd0, rbif}, 8'h01);
    step(1);
    chk("clr_no_rd2", {7'd0, rbif}, 8'h01);
    rd_en = 1'b1; step(1); rd_en = 1'b0;
    chk("rd_same_cycle", {7'd0, rbif}, 8'h01);
    flag_clr = 2'b10; step(1); flag_clr = 2'b00;
    chk("clr_after_rd", {7'd0, rbif}, 8'h00);
    step(2);
    chk("clr_after_rd2", {7'd0, rbif}, 8'h00);

    // Bit 4 as output must not flag; bit 1 is outside the IOC mask
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = 8'hEF; step(1); wr_en = 1'b0;
    pin_in = 8'h00; step(4);
    chk("ioc_tris_out", {7'd0, rbif}, 8'h00);
    rd_en = 1'b1; step(1); rd_en = 1'b0;
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = 8'hFF; step(1); wr_en = 1'b0;
    pin_in = 8'h02; step(4);
    chk("ioc_unmasked", {7'd0, rbif}, 8'h00);
    rd_en = 1'b1; step(1); rd_en = 1'b0;

    // Bit-0 edge flag
    intedg = 1'b1; step(1);
    chk("intedg_only", {7'd0, intf}, 8'h00);
    pin_in = 8'h03; step(2);
    chk("intf_early", {7'd0, intf}, 8'h00);
    step(1);
    chk("intf_rise", {7'd0, intf}, 8'h01);
    flag_clr = 2'b01; step(1); flag_clr = 2'b00;
    chk("intf_clr", {7'd0, intf}, 8'h00);
    pin_in = 8'h02; step(4);
    chk("intf_fall_ign", {7'd0, intf}, 8'h00);

    // Reset lands on the edge that would set rbif, overriding a PORT write
    pin_in = 8'h12; step(2);
    rst = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'h55; step(1);
    rst = 1'b0; wr_en = 1'b0;
    chk("rst_mid_rbif", {7'd0, rbif}, 8'h00);
    chk("rst_mid_tris", tris_val, 8'hFF);
    chk("rst_mid_out",  pin_out,  8'h00);

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 149) == 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_sel   = $urandom_range(0, 1);
      wr_data  = 8'($urandom);
      rd_en    = ($urandom_range(0, 3) == 0);
      intedg   = ($urandom_range(0, 19) == 0) ? ~intedg : intedg;
      flag_clr = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 2) == 0) pin_in = 8'($urandom);
      step(1);
    end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flag_clr = 2'b00;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
